uart_frame_loader: RTL and testbench
====================================

// Module: uart_frame_loader
// PURPOSE
//  Framing stage between uart_rx (po_data/po_flag) and Sdram_Control write port 1.
//  Parses PC-sent image packets: sync 0xA5 0x5A, slot byte, PIXELS bytes, 8-bit checksum.
//  Pulses FIFO load with the slot base address, then streams pixel bytes as write strobes.
//  Flags timeouts, bad slot numbers and checksum errors, so a broken transfer never
//  leaves a half-loaded slot marked valid.
// PARAMETERS
//  PIXELS       307200     pixel bytes per frame (640*480)
//  SLOTS        4          number of image slots; a slot byte >= SLOTS is rejected
//  BASE_ADDR    23'h100000 SDRAM word address of slot 0
//  SLOT_STRIDE  23'h04B000 address step between slots
//  TIMEOUT_CYC  2_500_000  max idle iCLK cycles between bytes inside a packet (50 ms @ 50 MHz)
// PORTS
//  iCLK        in   1   system clock (CLOCK_50 domain, same as uart_rx)
//  iRST_N      in   1   synchronous active-low reset
//  iRX_DATA    in   8   received byte (uart_rx po_data)
//  iRX_FLAG    in   1   1-cycle byte-valid strobe (uart_rx po_flag)
//  iENABLE     in   1   0: IDLE ignores sync bytes; a packet already in progress still completes
//  oWR_DATA    out  16  {8'h00, pixel byte} to WR1_DATA
//  oWR_EN      out  1   1-cycle write strobe to WR1
//  oLOAD       out  1   1-cycle FIFO address-load pulse (WR1_LOAD)
//  oWR_ADDR    out  23  BASE_ADDR + SLOT_STRIDE*slot; held until the next oLOAD
//  oBUSY       out  1   high from accepted 0xA5 until return to IDLE
//  oDONE       out  1   1-cycle pulse: frame complete, checksum good
//  oERR        out  1   1-cycle pulse on any abort
//  oERR_CODE   out  2   0 none, 1 timeout, 2 bad slot, 3 checksum; held until next packet start
//  oSLOT_VALID out  SLOTS  per-slot valid bits
// BEHAVIOUR
//  Reset (iRST_N low at a posedge): state IDLE, all outputs 0, oWR_ADDR = BASE_ADDR,
//   counters cleared. A reset mid-packet drops the partial frame; no oDONE/oERR.
//  States are evaluated only on cycles with iRX_FLAG=1, except the timeout check.
//   IDLE : byte 0xA5 and iENABLE=1 -> SYNC2; clear oERR_CODE; oBUSY=1.
//   SYNC2: 0x5A -> SLOT; 0xA5 -> stay in SYNC2; any other byte -> IDLE (silent, no oERR).
//   SLOT : byte < SLOTS -> DATA, register slot, oLOAD=1 next cycle, oWR_ADDR updated the
//          same cycle, clear oSLOT_VALID[slot], pix_cnt=0, sum=0;
//          byte >= SLOTS -> IDLE, oERR=1, code 2.
//   DATA : each byte -> oWR_EN=1 and oWR_DATA={8'h00,byte} on the next cycle (1-cycle latency);
//          sum <= sum + byte (mod 256); pix_cnt++. On the byte where pix_cnt == PIXELS-1 -> CHECK.
//   CHECK: byte == sum -> IDLE, oDONE=1, oSLOT_VALID[slot]=1;
//          otherwise -> IDLE, oERR=1, code 3.
//  Timeout: idle counter clears on each iRX_FLAG and while in IDLE; counts in all other states.
//   At TIMEOUT_CYC -> IDLE, oERR=1, code 1. If iRX_FLAG arrives on that same cycle, the byte wins.
//  Sync bytes are not special inside DATA/CHECK (raw payload).
//  oLOAD and the first oWR_EN are separated by >=1 byte time; no FIFO-full backpressure,
//   because UART byte rate << SDRAM rate.
//  Widths: pix_cnt and idle counter sized with $clog2; address math in 23 bits, no wrap checking.
// STRUCTURE
//  Package uart_frame_loader_pkg: SYNC0=8'hA5, SYNC1=8'h5A, state encoding
//   (IDLE,SYNC2,SLOT,DATA,CHECK), ERR_* code constants.
//  One sub-module: frame_byte_timeout (load/clear, count, expire pulse; parameter TIMEOUT_CYC).
//  Top level instantiates it in place of the direct uart_rx -> WR1 wiring; SLOT_VALID can
//   gate the display switch select.
// TESTING (bench overrides PIXELS=4, TIMEOUT_CYC=100, SLOTS=4)
//  1 Good packet A5 5A 02 10 20 30 40 A0 -> oLOAD once, oWR_ADDR=23'h196000; 4 oWR_EN with
//    data 0010,0020,0030,0040; oDONE; oSLOT_VALID=4'b0100.
//  2 Same packet with checksum A1 -> 4 writes, oERR, oERR_CODE=3, oSLOT_VALID[2]=0.
//  3 A5 5A 07 -> oERR, code 2, no oLOAD; followed by a good slot-0 packet -> oDONE,
//    oWR_ADDR=23'h100000.
//  4 A5 5A 01 10 then silence for 100 cycles -> oERR, code 1, state IDLE; next good packet accepted.
//  5 A5 A5 5A 00 + 4 bytes + sum -> accepted (resync); A5 33 -> silent return to IDLE, no oERR.
//  6 iRST_N low after 2 pixel bytes -> all outputs 0, no oDONE/oERR; iENABLE=0 with A5 -> oBUSY stays 0.

Source files
------------

// File: rtl/uart_frame_loader_pkg.sv
// Shared constants and types for the UART image-packet framing stage.
// Sync bytes, FSM encoding, error codes and the slot address helper.
package uart_frame_loader_pkg;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC2,
        ST_SLOT,
        ST_DATA,
        ST_CHECK
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_SLOT    = 2'd2;
    localparam logic [1:0] ERR_SUM     = 2'd3;

    function automatic logic [22:0] slot_addr(
        input logic [22:0] base,
        input logic [22:0] stride,
        input logic [7:0]  slot
    );
        return base + stride * {15'd0, slot};
    endfunction

endpackage

// File: rtl/uart_frame_loader_timeout.sv
// Inter-byte idle watchdog for the framing stage.
// Counts idle cycles while not cleared; expire pulses on the last one.
module frame_byte_timeout #(
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] idle_cnt;

    // A byte arriving on the final cycle clears the count, so it wins.
    assign expire = !clr && (idle_cnt == CNT_LAST);

    // Idle cycle counter, restarted by every byte and while parked in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (clr || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses A5 5A <slot> <pixels> <sum> packets from uart_rx into SDRAM WR1.
// Loads the slot base address, streams pixels, and tracks per-slot validity.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int          PIXELS      = 307200,
    parameter int          SLOTS       = 4,
    parameter logic [22:0] BASE_ADDR   = 23'h100000,
    parameter logic [22:0] SLOT_STRIDE = 23'h04B000,
    parameter int          TIMEOUT_CYC = 2_500_000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [7:0]       iRX_DATA,
    input  logic             iRX_FLAG,
    input  logic             iENABLE,
    output logic [15:0]      oWR_DATA,
    output logic             oWR_EN,
    output logic             oLOAD,
    output logic [22:0]      oWR_ADDR,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oERR,
    output logic [1:0]       oERR_CODE,
    output logic [SLOTS-1:0] oSLOT_VALID
);

    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
    localparam logic [31:0]      SLOT_LIM = 32'(SLOTS);

    state_t            state;
    logic [PIX_W-1:0]  pix_cnt;
    logic [7:0]        sum;
    logic [SLOT_W-1:0] slot_q;
    logic              tmo_clr;
    logic              tmo_expire;

    assign tmo_clr = iRX_FLAG || (state == ST_IDLE);

    frame_byte_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .clr   (tmo_clr),
        .expire(tmo_expire)
    );

    // Packet FSM; every output is registered and pulses default low
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state       <= ST_IDLE;
            pix_cnt     <= '0;
            sum         <= '0;
            slot_q      <= '0;
            oWR_DATA    <= '0;
            oWR_EN      <= 1'b0;
            oLOAD       <= 1'b0;
            oWR_ADDR    <= BASE_ADDR;
            oBUSY       <= 1'b0;
            oDONE       <= 1'b0;
            oERR        <= 1'b0;
            oERR_CODE   <= ERR_NONE;
            oSLOT_VALID <= '0;
        end else begin
            oWR_EN <= 1'b0;
            oLOAD  <= 1'b0;
            oDONE  <= 1'b0;
            oERR   <= 1'b0;
            if (iRX_FLAG) begin
                unique case (state)
                    ST_IDLE: begin
                        if (iRX_DATA == SYNC0 && iENABLE) begin
                            state     <= ST_SYNC2;
                            oBUSY     <= 1'b1;
                            oERR_CODE <= ERR_NONE;
                        end
                    end
                    ST_SYNC2: begin
                        if (iRX_DATA == SYNC1) begin
                            state <= ST_SLOT;
                        end else if (iRX_DATA != SYNC0) begin
                            state <= ST_IDLE;
                            oBUSY <= 1'b0;
                        end
                    end
                    ST_SLOT: begin
                        if ({24'd0, iRX_DATA} < SLOT_LIM) begin
                            state    <= ST_DATA;
                            slot_q   <= iRX_DATA[SLOT_W-1:0];
                            oLOAD    <= 1'b1;
                            oWR_ADDR <= slot_addr(BASE_ADDR,
                                                  SLOT_STRIDE,
                                                  iRX_DATA);
                            oSLOT_VALID[iRX_DATA[SLOT_W-1:0]] <= 1'b0;
                            pix_cnt  <= '0;
                            sum      <= '0;
                        end else begin
                            state     <= ST_IDLE;
                            oBUSY     <= 1'b0;
                            oERR      <= 1'b1;
                            oERR_CODE <= ERR_SLOT;
                        end
                    end
                    ST_DATA: begin
                        oWR_EN   <= 1'b1;
                        oWR_DATA <= {8'h00, iRX_DATA};
                        sum      <= sum + iRX_DATA;
                        pix_cnt  <= pix_cnt + 1'b1;
                        if (pix_cnt == PIX_LAST) begin
                            state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        state <= ST_IDLE;
                        oBUSY <= 1'b0;
                        if (iRX_DATA == sum) begin
                            oDONE               <= 1'b1;
                            oSLOT_VALID[slot_q] <= 1'b1;
                        end else begin
                            oERR      <= 1'b1;
                            oERR_CODE <= ERR_SUM;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        oBUSY <= 1'b0;
                    end
                endcase
            end else if (tmo_expire) begin
                state     <= ST_IDLE;
                oBUSY     <= 1'b0;
                oERR      <= 1'b1;
                oERR_CODE <= ERR_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader with a 4-pixel frame.
// Expected loads, writes and done/error events are queued as bytes are sent.
module tb_uart_frame_loader;

    localparam logic [2:0] EV_DONE = 3'b100;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n    = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_flag  = 1'b0;
    logic        enable   = 1'b1;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        load;
    logic [22:0] wr_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [3:0]  slot_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wr_q[$];
    logic [22:0] addr_q[$];
    logic [2:0]  evt_q[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    uart_frame_loader #(
        .PIXELS     (4),
        .SLOTS      (4),
        .BASE_ADDR  (23'h100000),
        .SLOT_STRIDE(23'h04B000),
        .TIMEOUT_CYC(100)
    ) dut (
        .iCLK       (CLOCK_50),
        .iRST_N     (rst_n),
        .iRX_DATA   (rx_data),
        .iRX_FLAG   (rx_flag),
        .iENABLE    (enable),
        .oWR_DATA   (wr_data),
        .oWR_EN     (wr_en),
        .oLOAD      (load),
        .oWR_ADDR   (wr_addr),
        .oBUSY      (busy),
        .oDONE      (done),
        .oERR       (err),
        .oERR_CODE  (err_code),
        .oSLOT_VALID(slot_valid)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Outputs settle after posedge; compare them on the falling edge
    always @(negedge CLOCK_50) begin
        if (wr_en) begin
            if (wr_q.size() == 0) chk("wr_extra", 1, 0);
            else chk("wr_data", {16'd0, wr_data}, {16'd0, wr_q.pop_front()});
        end
        if (load) begin
            if (addr_q.size() == 0) chk("load_extra", 1, 0);
            else chk("load_addr", {9'd0, wr_addr}, {9'd0, addr_q.pop_front()});
        end
        if (done || err) begin
            if (evt_q.size() == 0) begin
                chk("evt_extra", {29'd0, done, err_code}, 0);
            end else begin
                chk("evt", {28'd0, err, done, err_code},
                    {28'd0, ~evt_q[0][2], evt_q[0][2], evt_q[0][1:0]});
                void'(evt_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK_50);
        rx_data = b;
        rx_flag = 1'b1;
        @(negedge CLOCK_50);
        rx_flag = 1'b0;
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((wr_q.size() + addr_q.size() + evt_q.size()) != 0
               && n < lim) begin
            @(negedge CLOCK_50);
            n++;
        end
        repeat (4) @(negedge CLOCK_50);
        chk("pending", wr_q.size() + addr_q.size() + evt_q.size(), 0);
    endtask

    task automatic good_pkt(input logic [7:0] slot, input bit resync);
        logic [7:0] px;
        logic [7:0] sum = 8'h00;
        addr_q.push_back(23'h100000 + 23'h04B000 * {15'd0, slot});
        evt_q.push_back(EV_DONE);
        send_byte(8'hA5);
        if (resync) send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(slot);
        for (int i = 0; i < 4; i++) begin
            px = 8'($urandom);
            sum += px;
            wr_q.push_back({8'h00, px});
            send_byte(px);
        end
        send_byte(sum);
    endtask

    initial begin
        logic [7:0] pkt [8];
        pkt = '{8'hA5, 8'h5A, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};

        repeat (3) @(negedge CLOCK_50);
        chk("rst_addr", {9'd0, wr_addr}, 32'h100000);
        chk("rst_outs", {16'd0, wr_data, 4'd0, wr_en, load, busy, done,
                         err, err_code, 1'b0}, 0);
        chk("rst_valid", {28'd0, slot_valid}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // 1: good packet into slot 2
        addr_q.push_back(23'h196000);
        for (int i = 3; i < 7; i++) wr_q.push_back({8'h00, pkt[i]});
        evt_q.push_back(EV_DONE);
        for (int i = 0; i < 8; i++) begin
            send_byte(pkt[i]);
            if (i == 0) chk("busy_on", {31'd0, busy}, 1);
        end
        drain(50);
        chk("t1_valid", {28'd0, slot_valid}, 32'b0100);
        chk("t1_busy", {31'd0, busy}, 0);
        chk("t1_addr", {9'd0, wr_addr}, 32'h196000);

        // 2: same packet, bad checksum
        pkt[7] = 8'hA1;
        addr_q.push_back(23'h196000);
        for (int i = 3; i < 7; i++) wr_q.push_back({8'h00, pkt[i]});
        evt_q.push_back(3'b011);
        for (int i = 0; i < 8; i++) send_byte(pkt[i]);
        drain(50);
        chk("t2_code", {30'd0, err_code}, 3);
        chk("t2_valid", {28'd0, slot_valid}, 0);

        // 3: bad slot number, then a good slot-0 packet
        evt_q.push_back(3'b010);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h07);
        drain(50);
        chk("t3_code", {30'd0, err_code}, 2);
        chk("t3_busy", {31'd0, busy}, 0);
        good_pkt(8'h00, 1'b0);
        drain(50);
        chk("t3_addr", {9'd0, wr_addr}, 32'h100000);
        chk("t3_valid", {28'd0, slot_valid}, 32'b0001);
        chk("t3_code0", {30'd0, err_code}, 0);

        // 4: stall mid-frame until the watchdog fires
        addr_q.push_back(23'h14B000);
        wr_q.push_back(16'h0010);
        evt_q.push_back(3'b001);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h10);
        drain(200);
        chk("t4_code", {30'd0, err_code}, 1);
        chk("t4_busy", {31'd0, busy}, 0);
        chk("t4_state", {29'd0, dut.state}, 0);
        good_pkt(8'h03, 1'b0);
        drain(50);
        chk("t4_valid", {28'd0, slot_valid}, 32'b1001);

        // 5: doubled sync resyncs; A5 33 drops back silently
        good_pkt(8'h00, 1'b1);
        drain(50);
        chk("t5_valid", {28'd0, slot_valid}, 32'b1001);
        send_byte(8'hA5);
        chk("t5_busy1", {31'd0, busy}, 1);
        send_byte(8'h33);
        chk("t5_busy0", {31'd0, busy}, 0);
        drain(20);
        chk("t5_code", {30'd0, err_code}, 0);

        // 6: reset mid-frame, then a disabled loader ignores sync
        addr_q.push_back(23'h14B000);
        wr_q.push_back(16'h0011);
        wr_q.push_back(16'h0022);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        drain(20);
        rst_n = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        chk("t6_addr", {9'd0, wr_addr}, 32'h100000);
        chk("t6_outs", {16'd0, wr_data, 4'd0, wr_en, load, busy, done,
                        err, err_code, 1'b0}, 0);
        chk("t6_valid", {28'd0, slot_valid}, 0);
        rst_n = 1'b1;
        repeat (150) @(negedge CLOCK_50);
        chk("t6_quiet", {31'd0, busy}, 0);
        enable = 1'b0;
        send_byte(8'hA5);
        chk("t6_dis_busy", {31'd0, busy}, 0);
        send_byte(8'h5A);
        chk("t6_dis_state", {29'd0, dut.state}, 0);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
